// File: rtl/hazard_ctrl_gen.sv
// hazard_ctrl_gen: hazard / forwarding controller for the in-order LA32 pipeline
// (IF1, IF2, ID, then NFWD producer stages, stage 1 = EX ... stage NFWD = WB).
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   id_src_ren_i/reg_i     ID source operand read enables / indices (slice i)
//   id_pc_i, id_false_bp_i ID PC and "predicted taken on a non-branch" flag
//   st_wen_i/rd_i/late_i   per producer stage: GPR write, destination, result not forwardable
//   st_flush_i             per stage flush-younger request; exc_target_i goes with the WB one
//   ex_busy_i, ex_mispredict_i, ex_target_i   EX multicycle busy / branch correction
//   icache_miss_i, icache_not_ready_i, if_ready_i, dcache_miss_i   memory-side status
//   fwd_sel_o              per operand: 0 = regfile, s = forward from stage s
//   reg_wen_o/reg_flush_o  pipeline register controls, 0 = IF1/IF2, 1 = IF2/ID, 2 = ID/EX, 2+s = s->s+1
//   pc_wen_o, pc_redirect_o, pc_target_o   PC update controls
//   perf_stall_o, perf_redirect_o           saturating performance counters
module hazard_ctrl_gen #(
  parameter int NSRC = 3,
  parameter int NFWD = 4,
  parameter int REGW = 5,
  parameter int PCW  = 32,
  parameter int CNTW = 32,
  localparam int SELW = $clog2(NFWD + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NSRC-1:0]        id_src_ren_i,
  input  logic [NSRC*REGW-1:0]   id_src_reg_i,
  input  logic [PCW-1:0]         id_pc_i,
  input  logic                   id_false_bp_i,
  input  logic [NFWD-1:0]        st_wen_i,
  input  logic [NFWD*REGW-1:0]   st_rd_i,
  input  logic [NFWD-1:0]        st_late_i,
  input  logic [NFWD-1:0]        st_flush_i,
  input  logic [PCW-1:0]         exc_target_i,
  input  logic                   ex_busy_i,
  input  logic                   ex_mispredict_i,
  input  logic [PCW-1:0]         ex_target_i,
  input  logic                   icache_miss_i,
  input  logic                   icache_not_ready_i,
  input  logic                   if_ready_i,
  input  logic                   dcache_miss_i,
  output logic [NSRC*SELW-1:0]   fwd_sel_o,
  output logic [NFWD+1:0]        reg_wen_o,
  output logic [NFWD+1:0]        reg_flush_o,
  output logic                   pc_wen_o,
  output logic                   pc_redirect_o,
  output logic [PCW-1:0]         pc_target_o,
  output logic [CNTW-1:0]        perf_stall_o,
  output logic [CNTW-1:0]        perf_redirect_o
);

  typedef enum logic [0:0] {RUN = 1'b0, PEND = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [PCW-1:0]       tgt_q, tgt_d;
  logic [CNTW-1:0]      stall_q, redir_q;

  logic [NSRC*SELW-1:0] fwd_sel_s;
  logic                 hazard_late_s;
  logic [NFWD+1:0]      wen_s, flush_s, fsm_flush_s;
  logic                 pcw_s, fsm_pcw_s, fsm_redirect_s;
  logic                 req_s, req_exc_s;
  logic [PCW-1:0]       req_tgt_s, fsm_tgt_s, pend_tgt_s;
  logic [SELW-1:0]      oldest_s;

  // Forwarding select per operand: scanning WB down to EX lets the youngest match win.
  always_comb begin
    logic [SELW-1:0] sel_v;
    fwd_sel_s     = '0;
    hazard_late_s = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      sel_v = '0;
      if (id_src_ren_i[i] && (id_src_reg_i[i*REGW +: REGW] != '0)) begin
        for (int s = NFWD; s >= 1; s--) begin
          if (st_wen_i[s-1] && (st_rd_i[(s-1)*REGW +: REGW] == id_src_reg_i[i*REGW +: REGW])) begin
            sel_v = SELW'(s);
          end else begin
            sel_v = sel_v;
          end
        end
      end else begin
        sel_v = '0;
      end
      fwd_sel_s[i*SELW +: SELW] = sel_v;
      for (int s = 1; s <= NFWD; s++) begin
        hazard_late_s = hazard_late_s | ((sel_v == SELW'(s)) & st_late_i[s-1]);
      end
    end
  end

  // Oldest stage raising a flush request (0 when none).
  always_comb begin
    oldest_s = '0;
    for (int s = 1; s <= NFWD; s++) begin
      if (st_flush_i[s-1]) begin
        oldest_s = SELW'(s);
      end else begin
        oldest_s = oldest_s;
      end
    end
  end

  // Fixed-priority stall/flush/redirect-request resolution.
  always_comb begin
    wen_s     = '1;
    flush_s   = '0;
    pcw_s     = 1'b1;
    req_s     = 1'b0;
    req_exc_s = 1'b0;
    req_tgt_s = '0;
    if (dcache_miss_i) begin
      // Only the last register keeps moving so WB can retire while memory stalls.
      wen_s              = '0;
      wen_s[NFWD+1]      = 1'b1;
      flush_s[NFWD+1]    = 1'b1;
      pcw_s              = 1'b0;
    end else if (st_flush_i != '0) begin
      for (int b = 0; b <= NFWD + 1; b++) begin
        flush_s[b] = (b <= (int'(oldest_s) + 1));
      end
      if (oldest_s == SELW'(NFWD)) begin
        req_s     = 1'b1;
        req_exc_s = 1'b1;
        req_tgt_s = exc_target_i;
      end else begin
        pcw_s = 1'b0;
      end
    end else if (ex_busy_i) begin
      wen_s[2:0] = 3'b000;
      flush_s[3] = 1'b1;
      pcw_s      = 1'b0;
    end else if (hazard_late_s) begin
      wen_s[1:0] = 2'b00;
      flush_s[2] = 1'b1;
      pcw_s      = 1'b0;
    end else if (ex_mispredict_i) begin
      req_s        = 1'b1;
      req_tgt_s    = ex_target_i;
      flush_s[2:0] = 3'b111;
    end else if (id_false_bp_i) begin
      req_s        = 1'b1;
      req_tgt_s    = id_pc_i + PCW'(4);
      flush_s[1:0] = 2'b11;
    end else if (icache_miss_i) begin
      wen_s[0]   = 1'b0;
      flush_s[1] = 1'b1;
      pcw_s      = 1'b0;
    end else if (icache_not_ready_i) begin
      flush_s[0] = 1'b1;
      pcw_s      = 1'b0;
    end else begin
      pcw_s = 1'b1;
    end
  end

  // Redirect FSM: a request fetch cannot take is parked in PEND until if_ready.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    fsm_pcw_s      = pcw_s;
    fsm_redirect_s = 1'b0;
    fsm_tgt_s      = '0;
    fsm_flush_s    = flush_s;
    // Only a WB exception may replace a parked target; everything younger is moot.
    pend_tgt_s     = req_exc_s ? exc_target_i : tgt_q;
    case (state_q)
      RUN: begin
        if (req_s && if_ready_i) begin
          fsm_pcw_s      = 1'b1;
          fsm_redirect_s = 1'b1;
          fsm_tgt_s      = req_tgt_s;
        end else if (req_s) begin
          fsm_pcw_s = 1'b0;
          tgt_d     = req_tgt_s;
          state_d   = PEND;
        end else begin
          state_d = RUN;
        end
      end
      PEND: begin
        tgt_d          = pend_tgt_s;
        fsm_redirect_s = 1'b1;
        fsm_tgt_s      = pend_tgt_s;
        fsm_flush_s[0] = 1'b1;
        if (if_ready_i && !dcache_miss_i) begin
          fsm_pcw_s = 1'b1;
          state_d   = RUN;
        end else begin
          fsm_pcw_s = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Output stage: the reset cycle presents a fully flushed, frozen-PC pipeline.
  always_comb begin
    if (reset_i) begin
      fwd_sel_o     = '0;
      reg_wen_o     = '1;
      reg_flush_o   = '1;
      pc_wen_o      = 1'b0;
      pc_redirect_o = 1'b0;
      pc_target_o   = '0;
    end else begin
      fwd_sel_o     = fwd_sel_s;
      reg_wen_o     = wen_s;
      reg_flush_o   = fsm_flush_s;
      pc_wen_o      = fsm_pcw_s;
      pc_redirect_o = fsm_redirect_s;
      pc_target_o   = fsm_tgt_s;
    end
  end

  // State, parked target and saturating performance counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      tgt_q   <= '0;
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      if (!fsm_pcw_s && (stall_q != '1)) begin
        stall_q <= stall_q + CNTW'(1);
      end else begin
        stall_q <= stall_q;
      end
      if (fsm_pcw_s && fsm_redirect_s && (redir_q != '1)) begin
        redir_q <= redir_q + CNTW'(1);
      end else begin
        redir_q <= redir_q;
      end
    end
  end

  assign perf_stall_o    = stall_q;
  assign perf_redirect_o = redir_q;

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// tb_hazard_ctrl_gen: directed vectors for hazard_ctrl_gen (NFWD=4, CNTW=4).
// The driver pushes a hand-computed expectation for every cycle it drives; an
// independent monitor pops and compares on the falling edge.
module tb_hazard_ctrl_gen;

  localparam int NSRC = 3;
  localparam int NFWD = 4;
  localparam int REGW = 5;
  localparam int PCW  = 32;
  localparam int CNTW = 4;
  localparam int SELW = 3;

  logic                 clk;
  logic                 reset;
  logic [NSRC-1:0]      id_src_ren;
  logic [NSRC*REGW-1:0] id_src_reg;
  logic [PCW-1:0]       id_pc;
  logic                 id_false_bp;
  logic [NFWD-1:0]      st_wen, st_late, st_flush;
  logic [NFWD*REGW-1:0] st_rd;
  logic [PCW-1:0]       exc_target, ex_target;
  logic                 ex_busy, ex_mispredict, icache_miss, icache_not_ready, if_ready, dcache_miss;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic [NFWD+1:0]      reg_wen, reg_flush;
  logic                 pc_wen, pc_redirect;
  logic [PCW-1:0]       pc_target;
  logic [CNTW-1:0]      perf_stall, perf_redirect;

  typedef struct {
    string       nm;
    logic [8:0]  fwd;
    logic [5:0]  wen;
    logic [5:0]  flush;
    logic        pcw;
    logic        rdr;
    logic [31:0] tgt;
    logic [3:0]  st;
    logic [3:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_ctrl_gen #(.NSRC(NSRC), .NFWD(NFWD), .REGW(REGW), .PCW(PCW), .CNTW(CNTW)) dut (
    .clk_i(clk), .reset_i(reset),
    .id_src_ren_i(id_src_ren), .id_src_reg_i(id_src_reg),
    .id_pc_i(id_pc), .id_false_bp_i(id_false_bp),
    .st_wen_i(st_wen), .st_rd_i(st_rd), .st_late_i(st_late), .st_flush_i(st_flush),
    .exc_target_i(exc_target), .ex_busy_i(ex_busy), .ex_mispredict_i(ex_mispredict),
    .ex_target_i(ex_target), .icache_miss_i(icache_miss), .icache_not_ready_i(icache_not_ready),
    .if_ready_i(if_ready), .dcache_miss_i(dcache_miss),
    .fwd_sel_o(fwd_sel), .reg_wen_o(reg_wen), .reg_flush_o(reg_flush),
    .pc_wen_o(pc_wen), .pc_redirect_o(pc_redirect), .pc_target_o(pc_target),
    .perf_stall_o(perf_stall), .perf_redirect_o(perf_redirect)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    reset = 1'b0; id_src_ren = '0; id_src_reg = '0; id_pc = '0; id_false_bp = 1'b0;
    st_wen = '0; st_rd = '0; st_late = '0; st_flush = '0; exc_target = '0;
    ex_busy = 1'b0; ex_mispredict = 1'b0; ex_target = '0; icache_miss = 1'b0;
    icache_not_ready = 1'b0; if_ready = 1'b1; dcache_miss = 1'b0;
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input string nm, input logic [8:0] fwd, input logic [5:0] wen,
                            input logic [5:0] flush, input logic pcw, input logic rdr,
                            input logic [31:0] tgt, input logic [3:0] st, input logic [3:0] rd);
    exp_t e;
    e.nm = nm; e.fwd = fwd; e.wen = wen; e.flush = flush; e.pcw = pcw;
    e.rdr = rdr; e.tgt = tgt; e.st = st; e.rd = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if ({fwd_sel, reg_wen, reg_flush, pc_wen, pc_redirect, pc_target, perf_stall, perf_redirect} !==
          {e.fwd, e.wen, e.flush, e.pcw, e.rdr, e.tgt, e.st, e.rd}) begin
        n_bad++;
        $display("FAIL %s: got fwd=%h wen=%h flush=%h pcw=%b rdr=%b tgt=%h st=%0d rd=%0d, expected fwd=%h wen=%h flush=%h pcw=%b rdr=%b tgt=%h st=%0d rd=%0d",
                 e.nm, fwd_sel, reg_wen, reg_flush, pc_wen, pc_redirect, pc_target, perf_stall, perf_redirect,
                 e.fwd, e.wen, e.flush, e.pcw, e.rdr, e.tgt, e.st, e.rd);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    cyc(); reset = 1'b1;
    expect_out("reset", 9'h000, 6'h3f, 6'h3f, 1'b0, 1'b0, 32'h0, 4'd0, 4'd0);

    // Youngest producer wins, then older producer, then r0 never forwards.
    cyc(); id_src_ren = 3'b001; id_src_reg[0 +: 5] = 5'd5; st_wen = 4'b0101;
    st_rd[0 +: 5] = 5'd5; st_rd[10 +: 5] = 5'd5;
    expect_out("fwd_ex", 9'h001, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd0, 4'd0);
    cyc(); id_src_ren = 3'b001; id_src_reg[0 +: 5] = 5'd5; st_wen = 4'b0100;
    st_rd[0 +: 5] = 5'd5; st_rd[10 +: 5] = 5'd5;
    expect_out("fwd_mm2", 9'h003, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd0, 4'd0);
    cyc(); id_src_ren = 3'b001; id_src_reg[0 +: 5] = 5'd0; st_wen = 4'b0001; st_rd[0 +: 5] = 5'd0;
    expect_out("fwd_r0", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd0, 4'd0);

    // Load-use on MM1: two stall cycles, then forwarding from stage 2.
    for (int n = 0; n < 2; n++) begin
      cyc(); id_src_ren = 3'b010; id_src_reg[5 +: 5] = 5'd7; st_wen = 4'b0010;
      st_rd[5 +: 5] = 5'd7; st_late = 4'b0010;
      expect_out("load_use", 9'h010, 6'h3c, 6'h04, 1'b0, 1'b0, 32'h0, 4'(n), 4'd0);
    end
    cyc(); id_src_ren = 3'b010; id_src_reg[5 +: 5] = 5'd7; st_wen = 4'b0010; st_rd[5 +: 5] = 5'd7;
    expect_out("load_done", 9'h010, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd2, 4'd0);

    // Mispredict with fetch ready: same-cycle redirect.
    cyc(); ex_mispredict = 1'b1; ex_target = 32'h1c000100;
    expect_out("mispred_rdy", 9'h000, 6'h3f, 6'h07, 1'b1, 1'b1, 32'h1c000100, 4'd2, 4'd0);
    cyc();
    expect_out("after_rdr", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd2, 4'd1);

    // Mispredict while fetch busy: parked, overwritten by WB exception, then issued.
    cyc(); ex_mispredict = 1'b1; ex_target = 32'h1c000200; if_ready = 1'b0;
    expect_out("mispred_busy", 9'h000, 6'h3f, 6'h07, 1'b0, 1'b0, 32'h0, 4'd2, 4'd1);
    cyc(); if_ready = 1'b0;
    expect_out("pend_hold", 9'h000, 6'h3f, 6'h01, 1'b0, 1'b1, 32'h1c000200, 4'd3, 4'd1);
    cyc(); if_ready = 1'b0; st_flush = 4'b1000; exc_target = 32'h1c008000;
    expect_out("pend_exc", 9'h000, 6'h3f, 6'h3f, 1'b0, 1'b1, 32'h1c008000, 4'd4, 4'd1);
    cyc(); if_ready = 1'b0;
    expect_out("pend_new_tgt", 9'h000, 6'h3f, 6'h01, 1'b0, 1'b1, 32'h1c008000, 4'd5, 4'd1);
    cyc();
    expect_out("pend_issue", 9'h000, 6'h3f, 6'h01, 1'b1, 1'b1, 32'h1c008000, 4'd6, 4'd1);
    cyc();
    expect_out("back_run", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd6, 4'd2);

    // dcache_miss outranks a WB exception; the exception goes next cycle.
    cyc(); dcache_miss = 1'b1; st_flush = 4'b1000; exc_target = 32'h1c008000;
    expect_out("dmiss_exc", 9'h000, 6'h20, 6'h20, 1'b0, 1'b0, 32'h0, 4'd6, 4'd2);
    cyc(); st_flush = 4'b1000; exc_target = 32'h1c008000;
    expect_out("wb_exc", 9'h000, 6'h3f, 6'h3f, 1'b1, 1'b1, 32'h1c008000, 4'd7, 4'd2);
    cyc();
    expect_out("idle", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd7, 4'd3);

    // Remaining priority rows.
    cyc(); st_flush = 4'b0010;
    expect_out("mm1_flush", 9'h000, 6'h3f, 6'h0f, 1'b0, 1'b0, 32'h0, 4'd7, 4'd3);
    cyc(); ex_busy = 1'b1;
    expect_out("ex_busy", 9'h000, 6'h38, 6'h08, 1'b0, 1'b0, 32'h0, 4'd8, 4'd3);
    cyc(); id_false_bp = 1'b1; id_pc = 32'h1c000010;
    expect_out("false_bp", 9'h000, 6'h3f, 6'h03, 1'b1, 1'b1, 32'h1c000014, 4'd9, 4'd3);
    cyc(); icache_miss = 1'b1;
    expect_out("icache_miss", 9'h000, 6'h3e, 6'h02, 1'b0, 1'b0, 32'h0, 4'd9, 4'd4);
    cyc(); icache_not_ready = 1'b1;
    expect_out("ic_not_ready", 9'h000, 6'h3f, 6'h01, 1'b0, 1'b0, 32'h0, 4'd10, 4'd4);

    // Stall counter saturates at 15.
    for (int n = 0; n < 20; n++) begin
      cyc(); icache_not_ready = 1'b1;
      expect_out("stall_sat", 9'h000, 6'h3f, 6'h01, 1'b0, 1'b0, 32'h0,
                 4'(((11 + n) > 15) ? 15 : (11 + n)), 4'd4);
    end

    // Park a redirect, then reset mid-run: counters clear and FSM returns to RUN.
    cyc(); ex_mispredict = 1'b1; ex_target = 32'h1c000300; if_ready = 1'b0;
    expect_out("park_pre_rst", 9'h000, 6'h3f, 6'h07, 1'b0, 1'b0, 32'h0, 4'd15, 4'd4);
    cyc(); reset = 1'b1;
    expect_out("mid_reset", 9'h000, 6'h3f, 6'h3f, 1'b0, 1'b0, 32'h0, 4'd15, 4'd4);
    cyc();
    expect_out("post_rst", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd0, 4'd0);
    cyc();
    expect_out("post_rst2", 9'h000, 6'h3f, 6'h00, 1'b1, 1'b0, 32'h0, 4'd0, 4'd0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int n = 0; n < 5 && exp_q.size() > 0; n++) begin
      @(posedge clk);
    end
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_gen.md
Name: hazard_ctrl_gen

Overview:
- Parametrised successor hazard/forwarding controller for the in-order LA32 pipeline.
- Pipeline: IF1, IF2, ID, then NFWD producer stages (default EX, MM1, MM2, WB).
- Computes per-operand forwarding selects, stall/flush vectors for all pipeline registers, and PC redirect.
- Adds a registered redirect-pending state, so a redirect raised while fetch cannot accept a new PC is held, not lost, plus saturating stall/redirect performance counters.

Parameters:
NSRC, 3, number of ID source operands (j, k, d)
NFWD, 4, number of producer stages after ID; stage 1 = EX (youngest), stage NFWD = WB (commit)
REGW, 5, register index width
PCW, 32, PC width
CNTW, 32, performance counter width
SELW, $clog2(NFWD+1), forwarding select width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_src_ren  in  NSRC  operand i read-enable
id_src_reg  in  NSRC*REGW  operand i index, slice i
id_pc  in  PCW  ID-stage PC
id_false_bp  in  1  ID predicted taken on a non-branch
st_wen  in  NFWD  stage s writes a GPR (bit s-1)
st_rd  in  NFWD*REGW  stage s destination
st_late  in  NFWD  stage s result not yet forwardable (load data or CSR read pending)
st_flush  in  NFWD  stage s requests flush of all younger instructions
exc_target  in  PCW  exception/ertn entry, valid with st_flush[NFWD-1]
ex_busy  in  1  multicycle EX op incomplete
ex_mispredict  in  1  EX resolved branch mismatching prediction
ex_target  in  PCW  corrected PC for ex_mispredict
icache_miss  in  1  IF2 miss
icache_not_ready  in  1  IF1 request not accepted
if_ready  in  1  fetch can accept a redirect this cycle
dcache_miss  in  1  memory stage miss
fwd_sel  out  NSRC*SELW  0 = regfile, s = forward from stage s
reg_wen  out  NFWD+2  pipeline register write enable; index 0 = IF1/IF2, 1 = IF2/ID, 2 = ID/EX, 2+s = stage s to s+1
reg_flush  out  NFWD+2  pipeline register flush, same indexing
pc_wen  out  1  PC update enable
pc_redirect  out  1  PC loads pc_target
pc_target  out  PCW  redirect PC
perf_stall  out  CNTW  cycles with pc_wen==0
perf_redirect  out  CNTW  redirects issued

Behaviour:
Forwarding (combinational):
- Operand i with ren=1 and index != 0 takes the lowest s with st_wen[s-1] and st_rd[s]==index, so the youngest producer wins.
- No match, ren=0, or index==0 gives fwd_sel=0.
- hazard_late = any operand whose selected stage has st_late set.

Priority, first match, combinational:
1. dcache_miss: all reg_wen=0 except reg_wen[NFWD+1]=1; reg_flush[NFWD+1]=1; pc_wen=0.
2. Any st_flush: let k = oldest requesting stage.
   - reg_flush[0..k+1]=1, all reg_wen=1.
   - If k==NFWD: redirect request to exc_target.
   - Otherwise pc_wen=0 and no redirect.
3. ex_busy: reg_wen[0..2]=0; reg_flush[3]=1; pc_wen=0.
4. hazard_late: reg_wen[0..1]=0; reg_flush[2]=1; pc_wen=0.
5. ex_mispredict: redirect request to ex_target; reg_flush[0..2]=1.
6. id_false_bp: redirect request to id_pc+4; reg_flush[0..1]=1.
7. icache_miss: reg_wen[0]=0; reg_flush[1]=1; pc_wen=0.
8. icache_not_ready: reg_flush[0]=1; pc_wen=0.
9. Default: everything written, nothing flushed, pc_wen=1.
- Unlisted outputs default to reg_wen=1, reg_flush=0.

Redirect FSM, states RUN and PEND:
- RUN, request with if_ready=1: pc_wen=1, pc_redirect=1, pc_target = request target in the same cycle.
- RUN, request with if_ready=0: latch target, go to PEND; pc_wen=0.
- PEND:
  - pc_redirect=1 and pc_target = latched target.
  - reg_flush[0]=1 every cycle.
  - A new stage-NFWD exception request overwrites the latched target; lower-priority requests are ignored.
  - When if_ready=1: pc_wen=1, return to RUN.
- dcache_miss in PEND: hold state and target; pc_wen=0.
- Reset: RUN, latched target=0, pc_redirect=0.

Counters:
- perf_stall +1 per cycle with pc_wen==0.
- perf_redirect +1 per cycle with pc_wen && pc_redirect.
- Both saturate at all-ones and reset to 0.
- No count in the reset cycle.

Reset output values: pc_wen=0, pc_redirect=0, pc_target=0, all reg_flush=1, all reg_wen=1, fwd_sel=0.

Test Plan:
- EX and MM2 both write r5 (st_wen=4'b0101, st_rd=5), ID reads r5 as j -> fwd_sel_j=1; clear EX wen -> fwd_sel_j=3; j reads r0 -> 0.
- MM1 load to r7 (st_late[1]=1), ID k=r7 -> reg_wen[1:0]=0, reg_flush[2]=1, pc_wen=0, perf_stall +1 per cycle; drop st_late -> flows, fwd_sel_k=2.
- ex_mispredict, ex_target=0x1c000100, if_ready=1 -> same cycle pc_redirect=1, pc_target=0x1c000100, reg_flush[2:0]=3'b111, perf_redirect=1.
- ex_mispredict to 0x1c000200 with if_ready=0 for 3 cycles -> PEND; pc_redirect=1, pc_target held, reg_flush[0]=1; WB exception to 0x1c008000 in cycle 2 replaces target; if_ready=1 -> one redirect to 0x1c008000, back to RUN.
- dcache_miss plus st_flush[3] in the same cycle -> only reg_wen[5]/reg_flush[5] set, pc_wen=0; next cycle without miss -> reg_flush[5:0]=all 1, redirect to exc_target.
- CNTW=4, hold icache_not_ready 20 cycles -> perf_stall saturates at 15; reset mid-run -> counters 0, FSM RUN.
